ab_pattern_gen: RTL and testbench
=================================

# ab_pattern_gen

Synthesizable two-signal stimulus sequencer: drives the `a`/`b` pair through a programmed list of steps, each held for a programmable number of clock cycles. It is the driving end of the `a && b` check: it sits upstream of the immediate-assertion checker and produces the patterns the checker samples on `posedge clk`. It also counts, on chip, the cycles where `a && b` held during a run, so hardware and simulation report the same pass count.

## Interface
- `DEPTH`, default 8: number of step entries; power of two, ≥ 2.
- `HOLD_W`, default 4: width of the per-step hold count.
- `CNT_W`, default 16: width of the pass counter.
- `clk`  in  1: single clock; all logic on posedge.
- `rst`  in  1: reset, asynchronous and active-high.
- `cfg_we`  in  1: write one step entry.
- `cfg_addr`  in  $clog2(DEPTH): entry index.
- `cfg_ab`  in  2: step value; bit 1 = a, bit 0 = b.
- `cfg_hold`  in  HOLD_W: step lasts cfg_hold+1 cycles.
- `cfg_len`  in  $clog2(DEPTH)+1: active steps, 0..DEPTH; sampled at start.
- `loop_en`  in  1: wrap to step 0 after the last step; sampled continuously.
- `start`  in  1: single-cycle request to begin a run.
- `stop`  in  1: abort the run.
- `a`, `b`  out  1 each: registered pattern outputs.
- `busy`  out  1: run in progress.
- `done`  out  1: one-cycle pulse at normal completion.
- `step_idx`  out  $clog2(DEPTH): index of the step currently driven.
- `pass_cnt`  out  CNT_W: number of RUN cycles with a && b; saturates at all-ones.

## Operation
- States: IDLE, RUN, FIN.
- **IDLE**:
  - a = b = 0, busy = 0.
  - `cfg_we` writes `{cfg_ab, cfg_hold}` to entry `cfg_addr`.
  - `start` latches `cfg_len`. If the latched length is non-zero, go to RUN at step 0 and clear `pass_cnt`. If it is 0, go to FIN.
- **RUN**:
  - a/b = entry[step_idx].ab; a hold counter counts down from entry.hold.
  - When the hold counter reaches 0, advance `step_idx`.
  - If the step just finished was step len-1: with `loop_en`, go to step 0; otherwise go to FIN.
  - `pass_cnt` increments on each RUN cycle where the registered a && b = 1.
- **FIN**: a = b = 0, `done` = 1 for exactly one cycle, then IDLE. `pass_cnt` holds its value until the next start.
- `stop` in RUN: go to IDLE next cycle, a = b = 0, no `done` pulse, `pass_cnt` retained.
- `stop` and the last-step completion in the same cycle: `stop` wins, no `done`.
- `start` while busy or in FIN: ignored.
- `cfg_we` while not in IDLE: ignored (the memory is stable during a run).
- `cfg_len` > DEPTH: clamped to DEPTH.
- Reset, including mid-run:
  - State goes to IDLE; a, b, busy, done = 0; step_idx = 0; pass_cnt = 0.
  - All entries are cleared to ab = 00, hold = 0.

## Timing
- Run start:
  - `start` sampled at edge N: at edge N+1, busy = 1 and a/b = entry[0].ab.
  - Entry k with hold h drives a/b for exactly h+1 cycles.
- End of a run without looping:
  - Last step ends at edge M: at edge M+1, a = b = 0 and done = 1.
  - At edge M+2, done = 0 and the block is back in IDLE.
- Looping: step len-1 is followed directly by step 0. There is no idle gap and no `done` pulse.
- Zero-length start: done pulses at N+1. busy stays 0 throughout.
- `stop` sampled at edge S: busy = 0 and a = b = 0 at S+1.
- `pass_cnt`: the update is registered one cycle behind a/b. Its final value is valid when `done` is asserted.

## Structure
- Package `ab_pattern_pkg` holds:
  - the `state_e` enum (IDLE, RUN, FIN);
  - the `step_t` struct {logic [1:0] ab; logic [HOLD_W-1:0] hold};
  - the default parameter constants.
- One sub-module, `ab_pattern_mem`:
  - DEPTH × step_t register file, with async clear on `rst`.
  - One write port and one combinational read port.
- The FSM, hold counter and pass counter live in the top level.

## Test plan
- **Basic pattern.** Program 6 steps 00,11,10,01,00,11, all hold 0, len 6, no loop, then start.
  - a/b follow the list on consecutive cycles starting at N+1.
  - done pulses at N+7 and pass_cnt = 2.
- **Hold.** Program entry 0 = 11 with hold 4, len 1.
  - a = b = 1 for exactly 5 cycles, then done; pass_cnt = 5.
- **Loop then stop.** Program 2 steps 11,01, loop_en = 1, start, then assert stop after 7 cycles.
  - The pattern wraps with no gap; outputs go to 0 the cycle after stop, with no done.
  - pass_cnt = 4 (the 11 step occurred 4 times).
- **Boundaries.**
  - start with cfg_len = 0: done at N+1, busy never set.
  - cfg_len = 15 with DEPTH = 8: runs exactly 8 steps.
  - cfg_we and start during a run: memory contents and sequence unchanged.
- **Reset mid-run.** Assert rst asynchronously between clock edges during step 3.
  - a, b, busy and pass_cnt go to 0 immediately.
  - A later start with no writes drives 00 for len cycles.
- **Saturation.** CNT_W = 4, entry 11 with hold 15, loop_en = 1.
  - pass_cnt stops at 15 and never wraps.

Source files
------------

// File: rtl/ab_pattern_pkg.sv
// Shared types and default sizing for the a/b pattern sequencer.
// Step entries carry a hold field sized for the widest supported HOLD_W.
package ab_pattern_pkg;

    localparam int unsigned DEPTH_DEF  = 8;
    localparam int unsigned HOLD_W_DEF = 4;
    localparam int unsigned CNT_W_DEF  = 16;
    localparam int unsigned HOLD_MAX_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_e;

    typedef struct packed {
        logic [1:0]            ab;
        logic [HOLD_MAX_W-1:0] hold;
    } step_t;

endpackage

// File: rtl/ab_pattern_mem.sv
// Step register file: one write port, one combinational read port,
// every entry cleared asynchronously on rst.
module ab_pattern_mem
    import ab_pattern_pkg::*;
#(
    parameter  int unsigned DEPTH = DEPTH_DEF,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  step_t         wdata_i,
    input  logic [AW-1:0] raddr_i,
    output step_t         rdata_o
);

    step_t mem_q [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ab_pattern_gen.sv
// Two-signal stimulus sequencer: plays programmed a/b steps with per-step
// hold counts and counts cycles where the registered a && b was high.
module ab_pattern_gen
    import ab_pattern_pkg::*;
#(
    parameter  int unsigned DEPTH  = DEPTH_DEF,
    parameter  int unsigned HOLD_W = HOLD_W_DEF,
    parameter  int unsigned CNT_W  = CNT_W_DEF,
    localparam int unsigned IW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [IW-1:0]     cfg_addr,
    input  logic [1:0]        cfg_ab,
    input  logic [HOLD_W-1:0] cfg_hold,
    input  logic [IW:0]       cfg_len,
    input  logic              loop_en,
    input  logic              start,
    input  logic              stop,
    output logic              a,
    output logic              b,
    output logic              busy,
    output logic              done,
    output logic [IW-1:0]     step_idx,
    output logic [CNT_W-1:0]  pass_cnt
);

    localparam logic [IW:0] LEN_MAX = (IW+1)'(DEPTH);

    state_e                state_q;
    logic [IW-1:0]         step_q;
    logic [HOLD_MAX_W-1:0] hold_q;
    logic [IW:0]           len_q;
    logic                  a_q, b_q, busy_q, done_q;
    logic [CNT_W-1:0]      pass_q;

    step_t                 wr_step, rd_step;
    logic [IW-1:0]         rd_addr;
    logic [IW:0]           len_start;
    logic                  last_step;

    always_comb begin
        wr_step      = '0;
        wr_step.ab   = cfg_ab;
        wr_step.hold = HOLD_MAX_W'(cfg_hold);
    end

    assign len_start = (cfg_len > LEN_MAX) ? LEN_MAX : cfg_len;
    assign last_step = ({1'b0, step_q} == (len_q - (IW+1)'(1)));
    // Read address is the step that becomes active at the next edge, so a/b
    // and the hold count can be registered together with the step change.
    assign rd_addr   = (state_q == RUN && !last_step) ? step_q + IW'(1) : '0;

    ab_pattern_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .we_i    (cfg_we && state_q == IDLE),
        .waddr_i (cfg_addr),
        .wdata_i (wr_step),
        .raddr_i (rd_addr),
        .rdata_o (rd_step)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            step_q     <= '0;
            hold_q     <= '0;
            len_q      <= '0;
            {a_q, b_q} <= 2'b00;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (len_start != '0) begin
                            state_q    <= RUN;
                            len_q      <= len_start;
                            step_q     <= '0;
                            hold_q     <= rd_step.hold;
                            {a_q, b_q} <= rd_step.ab;
                            busy_q     <= 1'b1;
                            pass_q     <= '0;
                        end else begin
                            state_q <= FIN;
                            done_q  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (a_q && b_q && pass_q != '1) begin
                        pass_q <= pass_q + CNT_W'(1);
                    end
                    if (stop) begin
                        state_q    <= IDLE;
                        step_q     <= '0;
                        {a_q, b_q} <= 2'b00;
                        busy_q     <= 1'b0;
                    end else if (hold_q != '0) begin
                        hold_q <= hold_q - HOLD_MAX_W'(1);
                    end else if (last_step && !loop_en) begin
                        state_q    <= FIN;
                        {a_q, b_q} <= 2'b00;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                    end else begin
                        step_q     <= rd_addr;
                        hold_q     <= rd_step.hold;
                        {a_q, b_q} <= rd_step.ab;
                    end
                end
                FIN:     state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign a        = a_q;
    assign b        = b_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign step_idx = step_q;
    assign pass_cnt = pass_q;

endmodule

// File: tb/tb_ab_pattern_gen.sv
// Scoreboard bench for ab_pattern_gen: expected per-cycle outputs are expanded
// from a shadow copy of the step table and compared cycle by cycle.
module tb_ab_pattern_gen;

    localparam int DEPTH  = 8;
    localparam int A_NONE = 0;
    localparam int A_STOP = 1;
    localparam int A_DIST = 2;
    localparam int A_RST  = 3;

    typedef struct {
        int sig;
        int pass;
        bit chk_pass;
        int step;
        bit chk_step;
        int act;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_we;
    logic [2:0] cfg_addr;
    logic [1:0] cfg_ab;
    logic [3:0] cfg_hold;
    logic [3:0] cfg_len;
    logic       loop_en, start, stop;
    logic       a, b, busy, done;
    logic [2:0] step_idx;
    logic [15:0] pass_cnt;
    logic       a4, b4, busy4, done4;
    logic [2:0] step_idx4;
    logic [3:0] pass_cnt4;

    logic [1:0] tbl_ab [DEPTH];
    int         tbl_hold [DEPTH];
    exp_t       sb [$];
    int         n_total = 0;
    int         n_bad   = 0;

    always #5 clk = ~clk;

    ab_pattern_gen dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_ab(cfg_ab), .cfg_hold(cfg_hold), .cfg_len(cfg_len),
        .loop_en(loop_en), .start(start), .stop(stop),
        .a(a), .b(b), .busy(busy), .done(done),
        .step_idx(step_idx), .pass_cnt(pass_cnt)
    );

    ab_pattern_gen #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_ab(cfg_ab), .cfg_hold(cfg_hold), .cfg_len(cfg_len),
        .loop_en(loop_en), .start(start), .stop(stop),
        .a(a4), .b(b4), .busy(busy4), .done(done4),
        .step_idx(step_idx4), .pass_cnt(pass_cnt4)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic prog(input int addr, input logic [1:0] ab, input int hold);
        cfg_we   = 1'b1;
        cfg_addr = 3'(addr);
        cfg_ab   = ab;
        cfg_hold = 4'(hold);
        tick();
        cfg_we   = 1'b0;
        tbl_ab[addr]   = ab;
        tbl_hold[addr] = hold;
    endtask

    task automatic push(input int sig, input int pass, input bit cp, input int step,
                        input bit cs, input int act);
        exp_t e;
        e.sig = sig; e.pass = pass; e.chk_pass = cp;
        e.step = step; e.chk_step = cs; e.act = act;
        sb.push_back(e);
    endtask

    // Expected trace: every step k expands to hold[k]+1 busy cycles, then a
    // done cycle and an idle cycle; pass at cycle n counts 11 cycles before n.
    task automatic build(input int len_req, input bit loop, input int stop_at,
                         input int dist_at, input int rst_at);
        int len, n, k, r, p, act;
        len = (len_req > DEPTH) ? DEPTH : len_req;
        sb.delete();
        if (len == 0) begin
            push(4'b0001, 0, 1'b0, 0, 1'b0, A_NONE);
            push(4'b0000, 0, 1'b0, 0, 1'b0, A_NONE);
            return;
        end
        n = 0; k = 0; r = 0; p = 0;
        while (n < 5000) begin
            if (stop_at != 0 && n == stop_at) begin
                push(4'b0000, p, 1'b1, 0, 1'b1, A_NONE);
                push(4'b0000, p, 1'b1, 0, 1'b0, A_NONE);
                return;
            end
            if (k == len) begin
                push(4'b0001, p, 1'b1, 0, 1'b0, A_NONE);
                push(4'b0000, p, 1'b1, 0, 1'b0, A_NONE);
                return;
            end
            n++;
            act = (n == stop_at) ? A_STOP : (n == dist_at) ? A_DIST :
                  (n == rst_at) ? A_RST : A_NONE;
            push({28'd0, tbl_ab[k], 2'b10}, p, 1'b1, k, 1'b1, act);
            if (tbl_ab[k] == 2'b11) p++;
            r++;
            if (r > tbl_hold[k]) begin
                r = 0;
                k++;
                if (loop && k == len) k = 0;
            end
        end
    endtask

    task automatic run(input string name, input int len, input bit loop);
        exp_t e;
        int   cyc;
        cfg_len = 4'(len);
        loop_en = loop;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        cyc     = 1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check($sformatf("%s.sig[%0d]", name, cyc), {28'd0, a, b, busy, done}, e.sig);
            if (e.chk_pass) begin
                check($sformatf("%s.pass[%0d]", name, cyc), int'(pass_cnt), e.pass);
                check($sformatf("%s.pass4[%0d]", name, cyc), int'(pass_cnt4),
                      (e.pass > 15) ? 15 : e.pass);
            end
            if (e.chk_step)
                check($sformatf("%s.step[%0d]", name, cyc), int'(step_idx), e.step);
            case (e.act)
                A_STOP: stop = 1'b1;
                A_DIST: begin
                    cfg_we   = 1'b1;
                    cfg_addr = 3'd0;
                    cfg_ab   = ~tbl_ab[0];
                    cfg_hold = 4'd7;
                    start    = 1'b1;
                end
                A_RST: begin
                    #2 rst = 1'b1;
                    #1;
                    check($sformatf("%s.rst_sig", name), {28'd0, a, b, busy, done}, 0);
                    check($sformatf("%s.rst_pass", name), int'(pass_cnt), 0);
                    check($sformatf("%s.rst_step", name), int'(step_idx), 0);
                    @(posedge clk);
                    #1 rst = 1'b0;
                    sb.delete();
                    for (int i = 0; i < DEPTH; i++) begin
                        tbl_ab[i] = 2'b00;
                        tbl_hold[i] = 0;
                    end
                end
                default: ;
            endcase
            tick();
            stop   = 1'b0;
            cfg_we = 1'b0;
            start  = 1'b0;
            cyc++;
        end
        loop_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_ab = '0; cfg_hold = '0;
        cfg_len = '0; loop_en = 1'b0; start = 1'b0; stop = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            tbl_ab[i] = 2'b00;
            tbl_hold[i] = 0;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        tick();
        check("reset.sig", {28'd0, a, b, busy, done}, 0);
        check("reset.pass", int'(pass_cnt), 0);
        check("reset.step", int'(step_idx), 0);

        prog(0, 2'b00, 0); prog(1, 2'b11, 0); prog(2, 2'b10, 0);
        prog(3, 2'b01, 0); prog(4, 2'b00, 0); prog(5, 2'b11, 0);
        build(6, 1'b0, 0, 0, 0);
        run("basic", 6, 1'b0);

        prog(0, 2'b11, 4);
        build(1, 1'b0, 0, 0, 0);
        run("hold", 1, 1'b0);

        prog(0, 2'b11, 0); prog(1, 2'b01, 0);
        build(2, 1'b1, 7, 0, 0);
        run("loop_stop", 2, 1'b1);

        build(0, 1'b0, 0, 0, 0);
        run("len0", 0, 1'b0);

        for (int k = 0; k < DEPTH; k++) prog(k, 2'(k * 3 + 1), k % 3);
        build(15, 1'b0, 0, 3, 0);
        run("clamp_dist", 15, 1'b0);
        build(15, 1'b0, 0, 0, 0);
        run("clamp_rerun", 15, 1'b0);

        for (int k = 0; k < DEPTH; k++) prog(k, 2'b11, 1);
        build(6, 1'b0, 0, 0, 7);
        run("midrst", 6, 1'b0);
        build(4, 1'b0, 0, 0, 0);
        run("post_rst", 4, 1'b0);

        prog(0, 2'b11, 15);
        build(1, 1'b1, 40, 0, 0);
        run("sat", 1, 1'b1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
